// File: rtl/instr_fetcher.sv
// Instruction fetch unit: one valid/ready program-memory read per core FETCH, result latched for decode.
// Define INSTR_FETCHER_CACHE_EN to add a one-entry instruction cache in front of program memory.
module instr_fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

    localparam logic [2:0] CORE_FETCH  = 3'b001;
    localparam logic [2:0] CORE_DECODE = 3'b010;

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        FETCHING = 3'b001,
        FETCHED  = 3'b010
    } fetch_state_t;

    fetch_state_t                     state_q, state_d;
    logic                             valid_q, valid_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q, instr_d;

`ifdef INSTR_FETCHER_CACHE_EN
    logic                             cache_valid_q, cache_valid_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] cache_tag_q, cache_tag_d;
    logic [PROGRAM_MEM_DATA_BITS-1:0] cache_data_q, cache_data_d;
    logic                             cache_hit;

    assign cache_hit = cache_valid_q && (cache_tag_q == current_pc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cache_valid_q <= 1'b0;
            cache_tag_q   <= '0;
            cache_data_q  <= '0;
        end else begin
            cache_valid_q <= cache_valid_d;
            cache_tag_q   <= cache_tag_d;
            cache_data_q  <= cache_data_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        instr_d = instr_q;
`ifdef INSTR_FETCHER_CACHE_EN
        cache_valid_d = cache_valid_q;
        cache_tag_d   = cache_tag_q;
        cache_data_d  = cache_data_q;
`endif
        // A disabled core holds everything; ready strobes in that window are dropped.
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (core_state == CORE_FETCH) begin
`ifdef INSTR_FETCHER_CACHE_EN
                        if (cache_hit) begin
                            instr_d = cache_data_q;
                            state_d = FETCHED;
                        end else begin
                            valid_d = 1'b1;
                            addr_d  = current_pc;
                            state_d = FETCHING;
                        end
`else
                        valid_d = 1'b1;
                        addr_d  = current_pc;
                        state_d = FETCHING;
`endif
                    end
                end
                FETCHING: begin
                    // Request runs to completion even if the core has left FETCH.
                    if (mem_read_ready) begin
                        instr_d = mem_read_data;
                        valid_d = 1'b0;
                        state_d = FETCHED;
`ifdef INSTR_FETCHER_CACHE_EN
                        cache_valid_d = 1'b1;
                        cache_tag_d   = addr_q;
                        cache_data_d  = mem_read_data;
`endif
                    end
                end
                FETCHED: begin
                    if (core_state == CORE_DECODE) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
        end
    end

    assign mem_read_valid   = valid_q;
    assign mem_read_address = addr_q;
    assign fetcher_state    = state_q;
    assign instruction      = instr_q;

endmodule

// File: tb/tb_instr_fetcher.sv
// Self-checking bench for instr_fetcher: table-driven fetch vectors plus hand-written corner sequences.
module tb_instr_fetcher;

    localparam logic [2:0] CORE_IDLE   = 3'b000;
    localparam logic [2:0] CORE_FETCH  = 3'b001;
    localparam logic [2:0] CORE_DECODE = 3'b010;
    localparam logic [2:0] ST_IDLE     = 3'b000;
    localparam logic [2:0] ST_FETCHING = 3'b001;
    localparam logic [2:0] ST_FETCHED  = 3'b010;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;

    instr_fetcher #(
        .PROGRAM_MEM_ADDR_BITS(8),
        .PROGRAM_MEM_DATA_BITS(16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .core_state       (core_state),
        .current_pc       (current_pc),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .fetcher_state    (fetcher_state),
        .instruction      (instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pc;
        logic [7:0]  pc_later;
        logic [15:0] data;
        int          delay;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] instr;
    } exp_t;

    vec_t        vecs[5];
    exp_t        sb_q[$];
    int          checks;
    int          failures;
    logic [15:0] last_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One complete miss: request, optional ready wait (with pc change), completion, DECODE.
    task automatic run_fetch(input logic [7:0] pc, input logic [7:0] pc_later,
                             input logic [15:0] data, input int delay);
        exp_t e;
        int   n;
        @(negedge clk);
        core_state = CORE_FETCH;
        current_pc = pc;
        e.addr  = pc;
        e.instr = data;
        sb_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_read_valid && n < 8);
        chk("valid_latency", n, 1);
        chk("req_addr", mem_read_address, pc);
        core_state = CORE_IDLE;
        current_pc = pc_later;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("wait_valid", mem_read_valid, 1'b1);
            chk("wait_addr", mem_read_address, pc);
            chk("wait_state", fetcher_state, ST_FETCHING);
        end
        mem_read_ready = 1'b1;
        mem_read_data  = data;
        @(negedge clk);
        mem_read_ready = 1'b0;
        mem_read_data  = $urandom_range(0, 16'hFFFF);
        chk("fetch_to_fetched_cycles", n + delay + 1, delay + 2);
        chk("done_state", fetcher_state, ST_FETCHED);
        chk("done_valid", mem_read_valid, 1'b0);
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk("instruction", instruction, e.instr);
        end
        // Stray ready while FETCHED must not overwrite the instruction.
        mem_read_ready = 1'b1;
        mem_read_data  = ~data;
        @(negedge clk);
        mem_read_ready = 1'b0;
        chk("fetched_hold_state", fetcher_state, ST_FETCHED);
        chk("fetched_hold_instr", instruction, data);
        core_state = CORE_DECODE;
        @(negedge clk);
        core_state = CORE_IDLE;
        chk("decode_to_idle", fetcher_state, ST_IDLE);
        last_instr = data;
        $display("fetch pc=%02h data=%04h delay=%0d instr=%04h", pc, data, delay, instruction);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        last_instr = 16'h0000;
        reset          = 1'b1;
        enable         = 1'b1;
        core_state     = CORE_IDLE;
        current_pc     = 8'h00;
        mem_read_ready = 1'b0;
        mem_read_data  = 16'h0000;

        vecs[0] = '{pc: 8'h05, pc_later: 8'h05, data: 16'h3A21, delay: 0};
        vecs[1] = '{pc: 8'h05, pc_later: 8'h09, data: 16'hBEEF, delay: 10};
        vecs[2] = '{pc: 8'h80, pc_later: 8'h7F, data: 16'h0001, delay: 2};
        vecs[3] = '{pc: 8'hFF, pc_later: 8'h00, data: 16'hFFFF, delay: 1};
        vecs[4] = '{pc: 8'h00, pc_later: 8'hAA, data: 16'h8000, delay: 3};

        @(negedge clk);
        chk("reset_state", fetcher_state, ST_IDLE);
        chk("reset_valid", mem_read_valid, 1'b0);
        chk("reset_addr", mem_read_address, 8'h00);
        chk("reset_instr", instruction, 16'h0000);
        reset = 1'b0;
        $display("reset state=%0d valid=%0b", fetcher_state, mem_read_valid);

        for (int i = 0; i < 5; i++) begin
`ifdef INSTR_FETCHER_CACHE_EN
            do_reset();
`endif
            run_fetch(vecs[i].pc, vecs[i].pc_later, vecs[i].data, vecs[i].delay);
        end

        // Ready pulse while IDLE is ignored.
        @(negedge clk);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hFFFF;
        @(negedge clk);
        mem_read_ready = 1'b0;
        chk("idle_ready_state", fetcher_state, ST_IDLE);
        chk("idle_ready_instr", instruction, last_instr);
        chk("idle_ready_valid", mem_read_valid, 1'b0);
        $display("idle ready pulse state=%0d instr=%04h", fetcher_state, instruction);

        // Enable low mid-transaction freezes everything and drops ready.
        @(negedge clk);
        core_state = CORE_FETCH;
        current_pc = 8'h33;
        @(negedge clk);
        core_state = CORE_IDLE;
        chk("en_req_valid", mem_read_valid, 1'b1);
        chk("en_req_addr", mem_read_address, 8'h33);
        enable         = 1'b0;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hDEAD;
        current_pc     = 8'h44;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("en_frozen_state", fetcher_state, ST_FETCHING);
            chk("en_frozen_valid", mem_read_valid, 1'b1);
            chk("en_frozen_addr", mem_read_address, 8'h33);
            chk("en_frozen_instr", instruction, last_instr);
        end
        enable         = 1'b1;
        mem_read_ready = 1'b0;
        @(negedge clk);
        chk("en_resume_state", fetcher_state, ST_FETCHING);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h4455;
        @(negedge clk);
        mem_read_ready = 1'b0;
        chk("en_done_state", fetcher_state, ST_FETCHED);
        chk("en_done_instr", instruction, 16'h4455);
        core_state = CORE_DECODE;
        @(negedge clk);
        core_state = CORE_IDLE;
        chk("en_decode_idle", fetcher_state, ST_IDLE);
        last_instr = 16'h4455;
        $display("enable freeze fetch instr=%04h", instruction);

        // Asynchronous reset mid-FETCHING.
        @(negedge clk);
        core_state = CORE_FETCH;
        current_pc = 8'h44;
        @(negedge clk);
        core_state = CORE_IDLE;
        chk("rst_req_valid", mem_read_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_valid", mem_read_valid, 1'b0);
        chk("rst_async_state", fetcher_state, ST_IDLE);
        chk("rst_async_instr", instruction, 16'h0000);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h9999;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mem_read_ready = 1'b0;
        chk("rst_after_state", fetcher_state, ST_IDLE);
        chk("rst_after_instr", instruction, 16'h0000);
        chk("rst_after_valid", mem_read_valid, 1'b0);
        last_instr = 16'h0000;
        $display("reset mid-fetch state=%0d instr=%04h", fetcher_state, instruction);

`ifdef INSTR_FETCHER_CACHE_EN
        run_fetch(8'h05, 8'h05, 16'h3A21, 0);
        @(negedge clk);
        core_state = CORE_FETCH;
        current_pc = 8'h05;
        @(negedge clk);
        core_state = CORE_IDLE;
        chk("hit_valid", mem_read_valid, 1'b0);
        chk("hit_state", fetcher_state, ST_FETCHED);
        chk("hit_instr", instruction, 16'h3A21);
        core_state = CORE_DECODE;
        @(negedge clk);
        core_state = CORE_IDLE;
        chk("hit_decode_idle", fetcher_state, ST_IDLE);
        $display("cache hit pc=05 instr=%04h", instruction);
        run_fetch(8'h06, 8'h06, 16'h0606, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
